ql_packer: RTL and testbench
============================

# ql_packer

Compacting packer directly downstream of the 11-stage `et`/`ql` delay line. Each cycle it accepts one beat of eight 4-bit `ql` lanes plus the `et` end-of-strip flag. It drops empty lanes (value 4'hF) and packs the remaining nibbles, in order, into 32-bit words for the bitstream assembly stage. On `et` it flushes the residue as a short, padded final word.

## Interface
- `EMPTY`, default 4'hF: lane code meaning "no symbol". Also used as the padding nibble.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `i_et`  in  1  this beat is the last beat of a strip.
- `i_ql[1:8]`  in  8×4  lane values. Lane 1 is earliest in time. Lanes equal to `EMPTY` carry no symbol.
- `o_valid`  out  1  `o_data` is valid this cycle (single-cycle pulse; there is no backpressure).
- `o_last`  out  1  this word closes a strip. Only meaningful with `o_valid`.
- `o_cnt`  out  5  number of valid nibbles in `o_data`, range 0..15.
- `o_data`  out  64  packed nibbles. Nibble k sits at [4k+3:4k]; nibble 0 is the earliest.

## Operation
- Internal accumulator `acc` holds 0..7 leftover nibbles between cycles, in arrival order. `acc_cnt` is 3 bits.
- Every cycle, with `rst` low:
  - Compact the non-`EMPTY` lanes of `i_ql` in lane order 1→8, giving n = 0..8 nibbles.
  - Append them after the `acc` contents to form a temporary t of length c = `acc_cnt` + n, with c ≤ 15.
- Case `i_et` = 0:
  - If c ≥ 8: emit `o_valid`=1, `o_last`=0, `o_cnt`=8. `o_data[31:0]` = t nibbles 0..7 and `o_data[63:32]` = all `EMPTY`. `acc` ← t nibbles 8..c-1, `acc_cnt` ← c-8.
  - If c < 8: `o_valid`=0, `acc` ← t, `acc_cnt` ← c.
- Case `i_et` = 1 (flush):
  - Always emit `o_valid`=1, `o_last`=1, `o_cnt`=c. `o_data` = t nibbles 0..c-1, with every unused nibble = `EMPTY`.
  - `acc_cnt` ← 0. The next beat starts a new strip.
  - c = 0 still emits a marker word: `o_cnt`=0, data all `EMPTY`.
- An all-`EMPTY` beat with `i_et`=0 is a bubble. It has no effect except that `acc` is held.
- Lanes may be empty non-contiguously (e.g. only lanes 3 and 7 valid). The compaction result is identical to that of contiguous lanes.
- Only the full 4'hF code means empty. Values 4'h0..4'hE are all symbols.
- At most one output word per cycle is guaranteed by construction, because c ≤ 15.
- Nibbles in `acc` slots at or above `acc_cnt` are don't-care internally. The output must still show `EMPTY` in every unused slot.

## Timing
- Fully registered outputs. A beat presented at edge N produces its word (if any) on the outputs after edge N+1: latency 1 cycle.
- Throughput: one beat per cycle, sustained indefinitely.
- When no word is emitted, `o_valid`=0 and `o_last`=0. `o_cnt` and `o_data` may hold stale values but must not be X.
- Reset values: `o_valid`=0, `o_last`=0, `o_cnt`=0, `o_data`=all `EMPTY`, `acc_cnt`=0.
- Reset mid-strip: the residue in `acc` is discarded, no flush word is produced, and outputs take their reset values on the next edge.
- `rst` takes precedence over `i_et` arriving in the same cycle.

## Test plan
- **Reset:** hold `rst` 3 cycles with random inputs → `o_valid`=0, `o_data`=64'hFFFF_FFFF_FFFF_FFFF, `o_cnt`=0 throughout.
- **Full beats:** 3 beats with all lanes valid (values 0..7, then 8..E,0, then 1..8), `et` on the 3rd beat.
  - Cycles 1 and 2: `o_cnt`=8, `o_data[31:0]`=32'h76543210, then 32'h0EDCBA98.
  - Cycle 3: `o_last`=1, `o_cnt`=8, low word 32'h87654321.
- **Sparse lanes:** beat 1 with lanes 2,5 = 4'h3,4'hA and the rest F, then beat 2 with lanes 1..7 = 0..6 and lane 8 = F.
  - Beat 1: no output.
  - Beat 2: `o_cnt`=8, low word 32'h543210A3. `acc` keeps nibble 6.
- **Flush with c>8:** preload 7 nibbles (1..7), then a beat of 8 valid lanes (all 9) with `et`=1 → single word, `o_cnt`=15, `o_data`=64'hF999_9999_9765_4321, `o_last`=1.
- **Empty flush and bubbles:** 5 all-F beats, then an all-F beat with `et` → only one word, `o_cnt`=0, data all F, `o_last`=1.
- **Reset mid-strip:** preload 5 nibbles, then assert `rst` for 1 cycle, then a beat with 3 valid lanes and `et` → `o_cnt`=3, with no residue from the old strip in the word.

Source files
------------

// File: rtl/ql_packer.sv
// Compacting nibble packer: drops EMPTY lanes, packs surviving symbols into
// 32-bit words, and flushes the residue as a padded final word on et.
module ql_packer #(
    parameter logic [3:0] EMPTY = 4'hF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_et,
    input  logic [1:8][3:0] i_ql,
    output logic            o_valid,
    output logic            o_last,
    output logic [4:0]      o_cnt,
    output logic [63:0]     o_data
);

    logic [6:0][3:0]  acc_q, acc_d;
    logic [2:0]       acc_cnt_q, acc_cnt_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [15:0][3:0] data_q, data_d;

    logic [15:0][3:0] t;
    logic [4:0]       pos;

    // t = live acc nibbles followed by compacted lanes; every unused slot stays EMPTY.
    always_comb begin
        t   = {16{EMPTY}};
        pos = {2'b00, acc_cnt_q};
        for (int k = 0; k < 7; k++) begin
            t[k] = (3'(k) < acc_cnt_q) ? acc_q[k] : EMPTY;
        end
        for (int l = 1; l <= 8; l++) begin
            if (i_ql[l] != EMPTY) begin
                t[pos[3:0]] = i_ql[l];
                pos         = pos + 5'd1;
            end
        end
    end

    always_comb begin
        acc_d     = acc_q;
        acc_cnt_d = acc_cnt_q;
        valid_d   = 1'b0;
        last_d    = 1'b0;
        cnt_d     = cnt_q;
        data_d    = data_q;
        if (i_et) begin
            valid_d   = 1'b1;
            last_d    = 1'b1;
            cnt_d     = pos;
            data_d    = t;
            acc_cnt_d = 3'd0;
        end else if (pos >= 5'd8) begin
            valid_d   = 1'b1;
            cnt_d     = 5'd8;
            data_d    = {{8{EMPTY}}, t[7:0]};
            acc_d     = t[14:8];
            acc_cnt_d = 3'(pos - 5'd8);
        end else begin
            acc_d     = t[6:0];
            acc_cnt_d = pos[2:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= {7{EMPTY}};
            acc_cnt_q <= 3'd0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            cnt_q     <= 5'd0;
            data_q    <= {16{EMPTY}};
        end else begin
            acc_q     <= acc_d;
            acc_cnt_q <= acc_cnt_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
        end
    end

    assign o_valid = valid_q;
    assign o_last  = last_q;
    assign o_cnt   = cnt_q;
    assign o_data  = data_q;

endmodule

// File: tb/tb_ql_packer.sv
// Directed bench for ql_packer; lane 1 is the most significant nibble of the
// stimulus literal, so a beat literal reads left to right in arrival order.
module tb_ql_packer;

    logic            clk;
    logic            rst;
    logic            i_et;
    logic [1:8][3:0] i_ql;
    logic            o_valid;
    logic            o_last;
    logic [4:0]      o_cnt;
    logic [63:0]     o_data;

    int checks = 0;
    int errors = 0;

    ql_packer dut (
        .clk    (clk),
        .rst    (rst),
        .i_et   (i_et),
        .i_ql   (i_ql),
        .o_valid(o_valid),
        .o_last (o_last),
        .o_cnt  (o_cnt),
        .o_data (o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one beat and sample the registered result just after the edge.
    task automatic beat(input logic r, input logic et, input logic [31:0] q);
        @(negedge clk);
        rst  = r;
        i_et = et;
        i_ql = q;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string tag, input logic last, input logic [4:0] cnt,
                            input logic [63:0] data);
        chk({tag, ".valid"}, 64'(o_valid), 64'd1);
        chk({tag, ".last"},  64'(o_last),  64'(last));
        chk({tag, ".cnt"},   64'(o_cnt),   64'(cnt));
        chk({tag, ".data"},  o_data,       data);
    endtask

    task automatic chk_none(input string tag);
        chk({tag, ".valid"}, 64'(o_valid), 64'd0);
        chk({tag, ".last"},  64'(o_last),  64'd0);
    endtask

    initial begin
        rst  = 1'b1;
        i_et = 1'b0;
        i_ql = '1;

        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 1'($urandom), $urandom);
            chk("rst.valid", 64'(o_valid), 64'd0);
            chk("rst.cnt",   64'(o_cnt),   64'd0);
            chk("rst.data",  o_data,       64'hFFFF_FFFF_FFFF_FFFF);
        end

        beat(1'b0, 1'b0, 32'h0123_4567);
        chk_word("full1", 1'b0, 5'd8, 64'hFFFF_FFFF_7654_3210);
        beat(1'b0, 1'b0, 32'h89AB_CDE0);
        chk_word("full2", 1'b0, 5'd8, 64'hFFFF_FFFF_0EDC_BA98);
        beat(1'b0, 1'b1, 32'h1234_5678);
        chk_word("full3", 1'b1, 5'd8, 64'hFFFF_FFFF_8765_4321);

        beat(1'b0, 1'b0, 32'hF3FF_AFFF);
        chk_none("sparse1");
        beat(1'b0, 1'b0, 32'h0123_456F);
        chk_word("sparse2", 1'b0, 5'd8, 64'hFFFF_FFFF_5432_10A3);
        beat(1'b0, 1'b1, 32'hFFFF_FFFF);
        chk_word("sparse_res", 1'b1, 5'd1, 64'hFFFF_FFFF_FFFF_FFF6);

        beat(1'b0, 1'b0, 32'h1234_567F);
        chk_none("pre7");
        beat(1'b0, 1'b1, 32'h9999_9999);
        chk_word("flush15", 1'b1, 5'd15, 64'hF999_9999_9765_4321);

        for (int i = 0; i < 5; i++) begin
            beat(1'b0, 1'b0, 32'hFFFF_FFFF);
            chk_none("bubble");
        end
        beat(1'b0, 1'b1, 32'hFFFF_FFFF);
        chk_word("flush0", 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF);

        beat(1'b0, 1'b0, 32'h1234_5FFF);
        chk_none("pre5");
        beat(1'b1, 1'b1, 32'hABCD_EF01);
        chk_none("midrst");
        chk("midrst.cnt",  64'(o_cnt), 64'd0);
        chk("midrst.data", o_data,     64'hFFFF_FFFF_FFFF_FFFF);
        beat(1'b0, 1'b1, 32'hF1F2_F3FF);
        chk_word("postrst", 1'b1, 5'd3, 64'hFFFF_FFFF_FFFF_F321);

        beat(1'b0, 1'b0, 32'hFFFF_FFFF);
        chk_none("idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
